// File: rtl/nios_irq_pkg.sv
// rtl/nios_irq_pkg.sv - register map constants and helpers for the Nios II interrupt collector
package nios_irq_pkg;

    localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
    localparam logic [2:0] IRQ_REG_MASK    = 3'd1;
    localparam logic [2:0] IRQ_REG_MODE    = 3'd2;
    localparam logic [2:0] IRQ_REG_ACTIVE  = 3'd3;
    localparam logic [2:0] IRQ_REG_RAW     = 3'd4;
    localparam logic [2:0] IRQ_REG_OVERRUN = 3'd5;

    localparam int IRQ_MAX_SRC          = 16;
    localparam int IRQ_ACTIVE_VALID_BIT = 15;

    // Index of the lowest set bit; 0 when nothing is set (caller qualifies with a valid bit).
    function automatic logic [3:0] lowest_set(input logic [IRQ_MAX_SRC-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = i[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_irq_sync_edge.sv
// rtl/nios_irq_sync_edge.sv - per-line synchroniser plus one-cycle history for rising-edge detection
module nios_irq_sync_edge #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    output logic raw,
    output logic rise
);

    logic prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic s1;
            logic s2;

            // Two-flop synchroniser for sources from other clock domains.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                end else begin
                    s1 <= irq_in;
                    s2 <= s1;
                end
            end

            assign raw = s2;
        end else begin : g_bypass
            assign raw = irq_in;
        end
    endgenerate

    // Previous-cycle copy of raw; a rise needs raw low for a cycle to re-arm.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= raw;
    end

    assign rise = raw & ~prev;

endmodule

// File: rtl/nios_irq_collector.sv
// rtl/nios_irq_collector.sv - level/edge interrupt collector with mask, priority readout and overrun count
module nios_irq_collector
    import nios_irq_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    input  logic [N_SRC-1:0] irq_in,
    output logic             irq
);

    logic [N_SRC-1:0] raw;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [15:0]      overrun;

    logic             wr_pending, wr_mask, wr_mode, wr_overrun;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_nxt;
    logic             overrun_hit;
    logic             unused_wdata;

    logic [15:0]      pend16, mask16, mode16, raw16, act16;
    logic [15:0]      rd_mux;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            nios_irq_sync_edge #(.SYNC_EN(SYNC_EN)) u_sync_edge (
                .clk     (clk),
                .reset_n (reset_n),
                .irq_in  (irq_in[gi]),
                .raw     (raw[gi]),
                .rise    (rise[gi])
            );
        end
    endgenerate

    assign wr_pending = chipselect && !write_n && (address == IRQ_REG_PENDING);
    assign wr_mask    = chipselect && !write_n && (address == IRQ_REG_MASK);
    assign wr_mode    = chipselect && !write_n && (address == IRQ_REG_MODE);
    assign wr_overrun = chipselect && !write_n && (address == IRQ_REG_OVERRUN);
    assign unused_wdata = ^writedata;

    // Level bits follow raw; edge bits set on a rise (winning over W1C) and otherwise hold until cleared.
    always_comb begin
        clr         = wr_pending ? writedata[N_SRC-1:0] : '0;
        pending_nxt = (~mode & raw) | (mode & (rise | (pending & ~clr)));
        overrun_hit = |(mode & pending & rise & ~clr);
    end

    // Pending, mask and mode registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr_mask) mask <= writedata[N_SRC-1:0];
            if (wr_mode) mode <= writedata[N_SRC-1:0];
        end
    end

    // Saturating overrun counter; a bus write clears it even if an overrun lands that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 16'd0;
        end else if (wr_overrun) begin
            overrun <= 16'd0;
        end else if (overrun_hit && (overrun != 16'hFFFF)) begin
            overrun <= overrun + 16'd1;
        end
    end

    assign irq = |(pending & mask);

    // Zero-extend per-source vectors to bus width and build the read mux.
    always_comb begin
        pend16 = '0;
        mask16 = '0;
        mode16 = '0;
        raw16  = '0;
        pend16[N_SRC-1:0] = pending;
        mask16[N_SRC-1:0] = mask;
        mode16[N_SRC-1:0] = mode;
        raw16[N_SRC-1:0]  = raw;

        act16 = '0;
        if (|(pend16 & mask16)) begin
            act16[IRQ_ACTIVE_VALID_BIT] = 1'b1;
            act16[3:0] = lowest_set(pend16 & mask16);
        end

        rd_mux = '0;
        case (address)
            IRQ_REG_PENDING: rd_mux = pend16;
            IRQ_REG_MASK:    rd_mux = mask16;
            IRQ_REG_MODE:    rd_mux = mode16;
            IRQ_REG_ACTIVE:  rd_mux = act16;
            IRQ_REG_RAW:     rd_mux = raw16;
            IRQ_REG_OVERRUN: rd_mux = overrun;
            default:         rd_mux = '0;
        endcase
    end

    // Registered read data, sampled every clock regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'd0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_nios_irq_collector.sv
// tb/tb_nios_irq_collector.sv - directed vector bench for nios_irq_collector
module tb_nios_irq_collector;
    import nios_irq_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic [N-1:0]  irq_in;
    logic          irq;

    int total = 0;
    int bad   = 0;

    nios_irq_collector #(.N_SRC(N), .SYNC_EN(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [2:0]   addr;
        logic [15:0]  data;
        logic [N-1:0] src;
        logic         exp_irq;
        logic [15:0]  exp_rd;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        chk(name, readdata, exp);
    endtask

    task automatic pulse(input int s);
        irq_in[s] = 1'b1;
        tick();
        irq_in[s] = 1'b0;
    endtask

    initial begin
        // wr, rd, addr, data, irq_in, exp irq, exp readdata
        tbl[0]  = '{1, 0, IRQ_REG_MASK,    16'h0001, 8'h00, 1'b0, 16'h0000};
        tbl[1]  = '{1, 0, IRQ_REG_MODE,    16'h0000, 8'h00, 1'b0, 16'h0000};
        tbl[2]  = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h01, 1'b0, 16'h0000};
        tbl[3]  = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h01, 1'b0, 16'h0000};
        tbl[4]  = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h01, 1'b1, 16'h0000};
        tbl[5]  = '{0, 1, IRQ_REG_ACTIVE,  16'h0000, 8'h01, 1'b1, 16'h8000};
        tbl[6]  = '{1, 0, IRQ_REG_PENDING, 16'h0001, 8'h01, 1'b1, 16'h0000};
        tbl[7]  = '{0, 1, IRQ_REG_PENDING, 16'h0000, 8'h01, 1'b1, 16'h0001};
        tbl[8]  = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b1, 16'h0000};
        tbl[9]  = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b1, 16'h0000};
        tbl[10] = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b0, 16'h0000};
        tbl[11] = '{0, 1, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b0, 16'h0000};
        tbl[12] = '{1, 0, IRQ_REG_MODE,    16'h0004, 8'h00, 1'b0, 16'h0000};
        tbl[13] = '{1, 0, IRQ_REG_MASK,    16'h0004, 8'h00, 1'b0, 16'h0000};
        tbl[14] = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h04, 1'b0, 16'h0000};
        tbl[15] = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b0, 16'h0000};
        tbl[16] = '{0, 0, IRQ_REG_RAW,     16'h0000, 8'h00, 1'b1, 16'h0000};
        tbl[17] = '{0, 1, IRQ_REG_PENDING, 16'h0000, 8'h00, 1'b1, 16'h0004};
        tbl[18] = '{0, 1, IRQ_REG_ACTIVE,  16'h0000, 8'h00, 1'b1, 16'h8002};
        tbl[19] = '{1, 0, IRQ_REG_PENDING, 16'h0004, 8'h00, 1'b0, 16'h0000};
        tbl[20] = '{0, 1, IRQ_REG_PENDING, 16'h0000, 8'h00, 1'b0, 16'h0000};
        tbl[21] = '{0, 1, IRQ_REG_OVERRUN, 16'h0000, 8'h00, 1'b0, 16'h0000};

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_in     = '0;
        #12;
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        chk("reset_readdata", readdata, 16'h0000);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int k = 0; k < 22; k++) begin
            chipselect = tbl[k].wr | tbl[k].rd;
            write_n    = ~tbl[k].wr;
            address    = tbl[k].addr;
            writedata  = tbl[k].data;
            irq_in     = tbl[k].src;
            tick();
            chk($sformatf("vec%0d_irq", k), {15'd0, irq}, {15'd0, tbl[k].exp_irq});
            if (tbl[k].rd) chk($sformatf("vec%0d_rd", k), readdata, tbl[k].exp_rd);
        end
        idle(1);

        // Set-wins race: W1C lands on the same cycle as a fresh rise on source 2.
        pulse(2);
        idle(3);
        rd("race_pre_pending", IRQ_REG_PENDING, 16'h0004);
        pulse(2);
        idle(1);
        wr(IRQ_REG_PENDING, 16'h0004);
        chk("race_irq", {15'd0, irq}, 16'h0001);
        rd("race_pending", IRQ_REG_PENDING, 16'h0004);
        rd("race_overrun", IRQ_REG_OVERRUN, 16'h0000);

        // Priority and mask with pending 0x14.
        wr(IRQ_REG_MODE, 16'h0014);
        pulse(4);
        idle(3);
        rd("prio_pending", IRQ_REG_PENDING, 16'h0014);
        wr(IRQ_REG_MASK, 16'h0014);
        rd("prio_active_both", IRQ_REG_ACTIVE, 16'h8002);
        wr(IRQ_REG_MASK, 16'h0010);
        chk("prio_irq_on", {15'd0, irq}, 16'h0001);
        rd("prio_active_4", IRQ_REG_ACTIVE, 16'h8004);
        wr(IRQ_REG_MASK, 16'h0000);
        chk("prio_irq_off", {15'd0, irq}, 16'h0000);
        rd("prio_active_none", IRQ_REG_ACTIVE, 16'h0000);
        rd("prio_pending_kept", IRQ_REG_PENDING, 16'h0014);

        // Three rises on source 2 without clearing: the first sets, the next two overrun.
        wr(IRQ_REG_PENDING, 16'h00FF);
        rd("ovr_cleared_pending", IRQ_REG_PENDING, 16'h0000);
        for (int r = 0; r < 3; r++) begin
            pulse(2);
            idle(3);
        end
        rd("ovr_count2", IRQ_REG_OVERRUN, 16'h0002);

        // Saturation: sources 2 and 3 toggle in antiphase so every cycle carries a rise.
        wr(IRQ_REG_MODE, 16'h000C);
        for (int c = 0; c < 65700; c++) begin
            irq_in[2] = c[0];
            irq_in[3] = ~c[0];
            tick();
        end
        irq_in = '0;
        idle(4);
        rd("ovr_saturated", IRQ_REG_OVERRUN, 16'hFFFF);
        wr(IRQ_REG_OVERRUN, 16'h1234);
        rd("ovr_write_clear", IRQ_REG_OVERRUN, 16'h0000);
        rd("ovr_mode_readback", IRQ_REG_MODE, 16'h000C);

        // Asynchronous reset mid-operation.
        wr(IRQ_REG_MASK, 16'h000C);
        chk("pre_reset_irq", {15'd0, irq}, 16'h0001);
        irq_in = 8'h0C;
        idle(1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", {15'd0, irq}, 16'h0000);
        chk("async_reset_readdata", readdata, 16'h0000);
        irq_in = '0;
        idle(2);
        reset_n = 1'b1;
        for (int a = 0; a < 6; a++) begin
            rd($sformatf("post_reset_reg%0d", a), 3'(a), 16'h0000);
        end
        chk("post_reset_irq", {15'd0, irq}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
